// File: rtl/blend_sequencer_if.sv
// Signal bundle between blend_sequencer and its pixel source, VRAM ports and blend datapath.
// slave = the sequencer side, master = the environment that feeds and serves it.
interface blend_sequencer_if #(
  parameter int ADDRW = 19
) ();
  logic             in_valid;
  logic             in_ready;
  logic [ADDRW-1:0] in_addr;
  logic [7:0]       in_r;
  logic [7:0]       in_g;
  logic [7:0]       in_b;
  logic             in_stp;
  logic             in_transparent;
  logic             in_noblend;
  logic [1:0]       cfg_mode;
  logic             cfg_checkmask;
  logic             cfg_forcemask;

  logic             rd_req;
  logic [ADDRW-1:0] rd_addr;
  logic             rd_ack;
  logic             rd_valid;
  logic [15:0]      rd_data;

  logic [4:0]       bl_bg_r;
  logic [4:0]       bl_bg_g;
  logic [4:0]       bl_bg_b;
  logic [7:0]       bl_px_r;
  logic [7:0]       bl_px_g;
  logic [7:0]       bl_px_b;
  logic             bl_stp;
  logic             bl_transp;
  logic             bl_noblend;
  logic [1:0]       bl_mode;
  logic [7:0]       bl_r;
  logic [7:0]       bl_g;
  logic [7:0]       bl_b;

  logic             wr_req;
  logic [ADDRW-1:0] wr_addr;
  logic [15:0]      wr_data;
  logic             wr_ack;

  logic             busy;
  logic [15:0]      drop_cnt;

  modport slave (
    input  in_valid, in_addr, in_r, in_g, in_b, in_stp, in_transparent, in_noblend,
    input  cfg_mode, cfg_checkmask, cfg_forcemask,
    output in_ready,
    output rd_req, rd_addr,
    input  rd_ack, rd_valid, rd_data,
    output bl_bg_r, bl_bg_g, bl_bg_b, bl_px_r, bl_px_g, bl_px_b,
    output bl_stp, bl_transp, bl_noblend, bl_mode,
    input  bl_r, bl_g, bl_b,
    output wr_req, wr_addr, wr_data,
    input  wr_ack,
    output busy, drop_cnt
  );

  modport master (
    output in_valid, in_addr, in_r, in_g, in_b, in_stp, in_transparent, in_noblend,
    output cfg_mode, cfg_checkmask, cfg_forcemask,
    input  in_ready,
    input  rd_req, rd_addr,
    output rd_ack, rd_valid, rd_data,
    input  bl_bg_r, bl_bg_g, bl_bg_b, bl_px_r, bl_px_g, bl_px_b,
    input  bl_stp, bl_transp, bl_noblend, bl_mode,
    output bl_r, bl_g, bl_b,
    input  wr_req, wr_addr, wr_data,
    output wr_ack,
    input  busy, drop_cnt
  );
endinterface

// File: rtl/blend_sequencer.sv
// Single-pixel read-blend-write sequencer for VRAM semi-transparency.
// Define BLEND_SEQ_SKIPREAD_EN to skip the background read when the pixel needs no background.
//
// state  | meaning
// IDLE   | ready for a pixel; transparent pixels are dropped here
// RDREQ  | background read requested, waiting for rd_ack
// RDWAIT | waiting for rd_valid; mask-protected targets are dropped here
// BLEND  | blend datapath result captured into wr_data
// WRITE  | VRAM write requested, waiting for wr_ack
module blend_sequencer #(
  parameter int ADDRW = 19
) (
  input logic         clk,
  input logic         i_nrst,
  blend_sequencer_if.slave bus
);

  typedef enum logic [2:0] {IDLE, RDREQ, RDWAIT, BLEND, WRITE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [ADDRW-1:0] r_addr;
  logic [7:0]       r_px_r;
  logic [7:0]       r_px_g;
  logic [7:0]       r_px_b;
  logic             r_stp;
  logic             r_transp;
  logic             r_noblend;
  logic [1:0]       r_mode;
  logic             r_checkmask;
  logic             r_forcemask;
  logic [15:0]      r_bg;
  logic [15:0]      r_wr_data;
  logic [15:0]      r_drop_cnt;

  logic w_accept;
  logic w_discard;
  logic w_need_bg;
  logic w_bg_return;
  logic w_mask_skip;

  always_comb begin
    w_next      = r_state;
    w_accept    = (r_state == IDLE) && bus.in_valid;
    w_discard   = w_accept && bus.in_transparent && !bus.in_stp;
`ifdef BLEND_SEQ_SKIPREAD_EN
    w_need_bg   = (bus.in_stp && !bus.in_noblend) || bus.cfg_checkmask;
`else
    w_need_bg   = 1'b1;
`endif
    w_bg_return = (r_state == RDWAIT) && bus.rd_valid;
    w_mask_skip = w_bg_return && r_checkmask && bus.rd_data[15];
    case (r_state)
      IDLE:    if (w_accept && !w_discard) w_next = w_need_bg ? RDREQ : BLEND;
      RDREQ:   if (bus.rd_ack) w_next = RDWAIT;
      RDWAIT:  if (bus.rd_valid) w_next = w_mask_skip ? IDLE : BLEND;
      BLEND:   w_next = WRITE;
      WRITE:   if (bus.wr_ack) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!i_nrst) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (!i_nrst) begin
      r_addr      <= '0;
      r_px_r      <= '0;
      r_px_g      <= '0;
      r_px_b      <= '0;
      r_stp       <= 1'b0;
      r_transp    <= 1'b0;
      r_noblend   <= 1'b0;
      r_mode      <= '0;
      r_checkmask <= 1'b0;
      r_forcemask <= 1'b0;
      r_bg        <= '0;
      r_wr_data   <= '0;
      r_drop_cnt  <= '0;
    end else begin
      // Background starts at zero; only a completed read replaces it.
      if (w_accept) begin
        r_addr      <= bus.in_addr;
        r_px_r      <= bus.in_r;
        r_px_g      <= bus.in_g;
        r_px_b      <= bus.in_b;
        r_stp       <= bus.in_stp;
        r_transp    <= bus.in_transparent;
        r_noblend   <= bus.in_noblend;
        r_mode      <= bus.cfg_mode;
        r_checkmask <= bus.cfg_checkmask;
        r_forcemask <= bus.cfg_forcemask;
        r_bg        <= '0;
      end
      if (w_bg_return) r_bg <= bus.rd_data;
      if (r_state == BLEND)
        r_wr_data <= {r_stp | r_forcemask, bus.bl_b[7:3], bus.bl_g[7:3], bus.bl_r[7:3]};
      if ((w_discard || w_mask_skip) && (r_drop_cnt != 16'hFFFF))
        r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  assign bus.in_ready   = (r_state == IDLE);
  assign bus.busy       = (r_state != IDLE);
  assign bus.rd_req     = (r_state == RDREQ);
  assign bus.rd_addr    = r_addr;
  assign bus.wr_req     = (r_state == WRITE);
  assign bus.wr_addr    = r_addr;
  assign bus.wr_data    = r_wr_data;
  assign bus.drop_cnt   = r_drop_cnt;

  assign bus.bl_bg_r    = r_bg[4:0];
  assign bus.bl_bg_g    = r_bg[9:5];
  assign bus.bl_bg_b    = r_bg[14:10];
  assign bus.bl_px_r    = r_px_r;
  assign bus.bl_px_g    = r_px_g;
  assign bus.bl_px_b    = r_px_b;
  assign bus.bl_stp     = r_stp;
  assign bus.bl_transp  = r_transp;
  assign bus.bl_noblend = r_noblend;
  assign bus.bl_mode    = r_mode;

endmodule

// File: tb/tb_blend_sequencer.sv
// Self-checking bench for blend_sequencer: vector table, random pixels against a
// behavioural model, and a reset-during-read sequence. Also models the blend datapath.
`timescale 1ns/1ps
module tb_blend_sequencer;
  localparam int ADDRW = 19;
`ifdef BLEND_SEQ_SKIPREAD_EN
  localparam bit SKIPREAD = 1'b1;
`else
  localparam bit SKIPREAD = 1'b0;
`endif

  logic clk = 1'b0;
  logic i_nrst;
  always #5 clk = ~clk;

  blend_sequencer_if #(.ADDRW(ADDRW)) bus ();
  blend_sequencer #(.ADDRW(ADDRW)) dut (.clk(clk), .i_nrst(i_nrst), .bus(bus));

  // External blend datapath: background expanded from 5 to 8 bits, modes avg/add/sub/add-quarter.
  function automatic logic [7:0] blend8(input logic [4:0] bg5, input logic [7:0] px,
                                        input logic [1:0] mode, input logic stp, input logic noblend);
    int b;
    int f;
    int s;
    b = int'(bg5) * 8;
    f = int'(px);
    if (noblend || !stp) return px;
    case (mode)
      2'd0:    s = (b + f) / 2;
      2'd1:    s = b + f;
      2'd2:    s = b - f;
      default: s = b + f / 4;
    endcase
    if (s < 0) s = 0;
    if (s > 255) s = 255;
    return 8'(s);
  endfunction

  always_comb begin
    bus.bl_r = blend8(bus.bl_bg_r, bus.bl_px_r, bus.bl_mode, bus.bl_stp, bus.bl_noblend);
    bus.bl_g = blend8(bus.bl_bg_g, bus.bl_px_g, bus.bl_mode, bus.bl_stp, bus.bl_noblend);
    bus.bl_b = blend8(bus.bl_bg_b, bus.bl_px_b, bus.bl_mode, bus.bl_stp, bus.bl_noblend);
  end

  typedef struct {
    logic [ADDRW-1:0] addr;
    logic [7:0]  r, g, b;
    logic        stp, transp, noblend;
    logic [1:0]  mode;
    logic        cm, fm;
    logic [15:0] bg;
    int          rd_dly, val_dly, wr_dly;
    logic        exp_rd, exp_wr;
    logic [15:0] exp_data;
    logic        exp_drop;
  } vec_t;

  typedef struct {
    logic        saw_rd, saw_wr, addr_bad, excl_bad, busy_bad, stab_bad, ret_bad, timeout;
    logic [15:0] wr_data;
    int          lat;
  } res_t;

  int n_cmp = 0;
  int n_err = 0;
  int exp_drops = 0;
  vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mkv(input logic [ADDRW-1:0] addr, input logic [7:0] r, input logic [7:0] g,
                               input logic [7:0] b, input logic stp, input logic tr, input logic nb,
                               input logic [1:0] mode, input logic cm, input logic fm, input logic [15:0] bg,
                               input int rd, input int vd, input int wd, input logic erd, input logic ewr,
                               input logic [15:0] edata, input logic edrop);
    vec_t v;
    v.addr = addr; v.r = r; v.g = g; v.b = b;
    v.stp = stp; v.transp = tr; v.noblend = nb; v.mode = mode; v.cm = cm; v.fm = fm; v.bg = bg;
    v.rd_dly = rd; v.val_dly = vd; v.wr_dly = wd;
    v.exp_rd = erd; v.exp_wr = ewr; v.exp_data = edata; v.exp_drop = edrop;
    return v;
  endfunction

  // Reference behaviour straight from the pixel rules.
  function automatic vec_t model(input vec_t vin);
    vec_t v;
    logic disc, need, skip;
    logic [15:0] bgu;
    logic [7:0] br, bgr, bb;
    v = vin;
    disc = v.transp && !v.stp;
    need = SKIPREAD ? ((v.stp && !v.noblend) || v.cm) : 1'b1;
    skip = !disc && need && v.cm && v.bg[15];
    bgu  = need ? v.bg : 16'h0000;
    br  = blend8(bgu[4:0],   v.r, v.mode, v.stp, v.noblend);
    bgr = blend8(bgu[9:5],   v.g, v.mode, v.stp, v.noblend);
    bb  = blend8(bgu[14:10], v.b, v.mode, v.stp, v.noblend);
    v.exp_rd   = !disc && need;
    v.exp_wr   = !disc && !skip;
    v.exp_drop = disc || skip;
    v.exp_data = {v.stp | v.fm, bb[7:3], bgr[7:3], br[7:3]};
    return v;
  endfunction

  // Offers one pixel, then plays memory: stray rd_valid while rd_ack is withheld,
  // stray rd_ack while wr_ack is withheld.
  task automatic run_pixel(input vec_t v, output res_t r);
    int n, k, ack_cnt, vcnt, wcnt, phase;
    bit acked;
    r.saw_rd = 0; r.saw_wr = 0; r.addr_bad = 0; r.excl_bad = 0; r.busy_bad = 0;
    r.stab_bad = 0; r.ret_bad = 0; r.timeout = 0; r.wr_data = '0; r.lat = -1;
    n = 0; k = 0; ack_cnt = 0; vcnt = 0; wcnt = 0; phase = 0; acked = 0;
    bus.in_valid = 1'b1; bus.in_addr = v.addr;
    bus.in_r = v.r; bus.in_g = v.g; bus.in_b = v.b;
    bus.in_stp = v.stp; bus.in_transparent = v.transp; bus.in_noblend = v.noblend;
    bus.cfg_mode = v.mode; bus.cfg_checkmask = v.cm; bus.cfg_forcemask = v.fm;
    while (!bus.in_ready) begin
      n++;
      if (n > 50) begin r.timeout = 1; break; end
      @(negedge clk);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.in_ready && !r.timeout) begin
      if (acked) r.ret_bad = 1;
      bus.rd_ack = 1'b0; bus.wr_ack = 1'b0; bus.rd_valid = 1'b0; bus.rd_data = 16'hFFFF;
      if (bus.rd_req && bus.wr_req) r.excl_bad = 1;
      if (!bus.busy) r.busy_bad = 1;
      if (bus.rd_req) begin
        r.saw_rd = 1;
        if (bus.rd_addr !== v.addr) r.addr_bad = 1;
        if (ack_cnt == v.rd_dly) begin bus.rd_ack = 1'b1; phase = 1; end
        else begin ack_cnt++; bus.rd_valid = 1'b1; end
      end else if (bus.wr_req) begin
        if (!r.saw_wr) begin r.saw_wr = 1; r.wr_data = bus.wr_data; r.lat = k; end
        else if (bus.wr_data !== r.wr_data) r.stab_bad = 1;
        if (bus.wr_addr !== v.addr) r.addr_bad = 1;
        if (wcnt == v.wr_dly) begin bus.wr_ack = 1'b1; acked = 1; end
        else begin wcnt++; bus.rd_ack = 1'b1; end
      end else if (phase == 1) begin
        if (vcnt == v.val_dly) begin bus.rd_valid = 1'b1; bus.rd_data = v.bg; phase = 2; end
        else vcnt++;
      end
      k++;
      n++;
      if (n > 200) r.timeout = 1;
      @(negedge clk);
    end
    bus.rd_ack = 1'b0; bus.wr_ack = 1'b0; bus.rd_valid = 1'b0;
  endtask

  task automatic check_vec(input string tag, input vec_t v, input res_t r);
    int lat_exp;
    lat_exp = v.exp_rd ? (3 + v.rd_dly + v.val_dly) : 1;
    if (v.exp_drop && exp_drops != 65535) exp_drops++;
    chk({tag, " rd_req"}, 32'(r.saw_rd), 32'(v.exp_rd));
    chk({tag, " wr_req"}, 32'(r.saw_wr), 32'(v.exp_wr));
    if (v.exp_wr) begin
      chk({tag, " wr_data"}, 32'(r.wr_data), 32'(v.exp_data));
      chk({tag, " latency"}, 32'(r.lat), 32'(lat_exp));
    end
    chk({tag, " protocol flags"},
        32'({r.addr_bad, r.excl_bad, r.busy_bad, r.stab_bad, r.ret_bad, r.timeout}), 32'(0));
    chk({tag, " drop_cnt"}, 32'(bus.drop_cnt), 32'(exp_drops));
    chk({tag, " idle after"}, 32'({bus.in_ready, bus.busy}), 32'(2'b10));
  endtask

  initial begin
    vec_t v;
    res_t r;
    bit   quiet;

    tbl[0] = mkv(19'h12345, 8'hF8, 8'h80, 8'h08, 0, 0, 1, 2'd0, 0, 0, 16'h0000, 0, 0, 0, !SKIPREAD, 1, 16'h061F, 0);
    tbl[1] = mkv(19'h00100, 8'h40, 8'h40, 8'h40, 1, 0, 0, 2'd1, 0, 0, 16'h0842, 0, 0, 0, 1, 1, 16'hA94A, 0);
    tbl[2] = mkv(19'h7FFFF, 8'h10, 8'h20, 8'h30, 0, 0, 0, 2'd0, 1, 0, 16'h8000, 1, 1, 0, 1, 0, 16'h0000, 1);
    tbl[3] = mkv(19'h00055, 8'h00, 8'h00, 8'h00, 0, 1, 0, 2'd0, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 16'h0000, 1);
    tbl[4] = mkv(19'h2AAAA, 8'h80, 8'h40, 8'h20, 1, 0, 0, 2'd0, 0, 0, 16'h7FFF, 5, 2, 3, 1, 1, 16'hC677, 0);
    tbl[5] = mkv(19'h00001, 8'h08, 8'h10, 8'h18, 0, 0, 1, 2'd2, 1, 1, 16'h7C00, 0, 0, 0, 1, 1, 16'h8C41, 0);
    tbl[6] = mkv(19'h3C3C3, 8'h80, 8'h80, 8'h08, 1, 0, 0, 2'd2, 0, 0, 16'h0421, 0, 0, 1, 1, 1, 16'h8000, 0);
    tbl[7] = mkv(19'h00ABC, 8'h40, 8'h80, 8'hC0, 1, 1, 0, 2'd3, 0, 0, 16'h0000, 2, 0, 0, 1, 1, 16'h9882, 0);

    i_nrst = 1'b0;
    bus.in_valid = 1'b0; bus.in_addr = '0; bus.in_r = '0; bus.in_g = '0; bus.in_b = '0;
    bus.in_stp = 1'b0; bus.in_transparent = 1'b0; bus.in_noblend = 1'b0;
    bus.cfg_mode = '0; bus.cfg_checkmask = 1'b0; bus.cfg_forcemask = 1'b0;
    bus.rd_ack = 1'b0; bus.rd_valid = 1'b0; bus.rd_data = '0; bus.wr_ack = 1'b0;
    repeat (3) @(negedge clk);
    i_nrst = 1'b1;
    chk("reset in_ready/busy", 32'({bus.in_ready, bus.busy}), 32'(2'b10));
    chk("reset rd_req/wr_req", 32'({bus.rd_req, bus.wr_req}), 32'(0));
    chk("reset drop_cnt", 32'(bus.drop_cnt), 32'(0));
    chk("reset wr_data", 32'(bus.wr_data), 32'(0));

    for (int i = 0; i < 8; i++) begin
      run_pixel(tbl[i], r);
      check_vec($sformatf("vec%0d", i), tbl[i], r);
    end

    for (int i = 0; i < 150; i++) begin
      v.addr = ADDRW'($urandom);
      v.r = 8'($urandom); v.g = 8'($urandom); v.b = 8'($urandom);
      v.stp = 1'($urandom_range(0, 1));
      v.transp = ($urandom_range(0, 3) == 0);
      v.noblend = 1'($urandom_range(0, 1));
      v.mode = 2'($urandom_range(0, 3));
      v.cm = ($urandom_range(0, 2) == 0);
      v.fm = 1'($urandom_range(0, 1));
      v.bg = 16'($urandom);
      v.rd_dly = int'($urandom_range(0, 3));
      v.val_dly = int'($urandom_range(0, 3));
      v.wr_dly = int'($urandom_range(0, 3));
      v = model(v);
      run_pixel(v, r);
      check_vec($sformatf("rnd%0d", i), v, r);
    end

    // Reset while waiting for the background word; the late rd_valid must be ignored.
    bus.in_valid = 1'b1; bus.in_addr = 19'h0ABCD;
    bus.in_r = 8'h11; bus.in_g = 8'h22; bus.in_b = 8'h33;
    bus.in_stp = 1'b1; bus.in_transparent = 1'b0; bus.in_noblend = 1'b0;
    bus.cfg_mode = 2'd1; bus.cfg_checkmask = 1'b1; bus.cfg_forcemask = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("rstseq rd_req", 32'({bus.rd_req, bus.in_ready}), 32'(2'b10));
    bus.rd_ack = 1'b1;
    @(negedge clk);
    bus.rd_ack = 1'b0;
    chk("rstseq in RDWAIT", 32'({bus.busy, bus.rd_req, bus.wr_req}), 32'(3'b100));
    i_nrst = 1'b0;
    @(negedge clk);
    i_nrst = 1'b1;
    exp_drops = 0;
    chk("rstseq idle", 32'({bus.in_ready, bus.busy}), 32'(2'b10));
    bus.rd_valid = 1'b1; bus.rd_data = 16'h8123;
    quiet = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.rd_valid = 1'b0;
      if (bus.wr_req || bus.rd_req || bus.busy) quiet = 1'b0;
    end
    chk("rstseq no activity", 32'(quiet), 32'(1));
    chk("rstseq drop_cnt", 32'(bus.drop_cnt), 32'(0));
    chk("rstseq holding px", 32'({bus.bl_px_r, bus.bl_px_g, bus.bl_px_b}), 32'(0));
    chk("rstseq holding bg", 32'({bus.bl_bg_r, bus.bl_bg_g, bus.bl_bg_b}), 32'(0));
    chk("rstseq wr_data", 32'(bus.wr_data), 32'(0));

    run_pixel(tbl[1], r);
    check_vec("post-reset add", tbl[1], r);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
